// File: rtl/traffic_pkg.sv
// Shared constants and press-FSM encoding for the traffic-light
// operator input path.
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } press_state_t;

    localparam int CLK_HZ       = 1000000;
    localparam int DB_CYC_DEF   = 20000;
    localparam int LONG_CYC_DEF = 1000000;

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser followed by a counting debouncer that only
// accepts a new level after it has persisted for DB_CYC cycles.
module btn_debouncer
    import traffic_pkg::*;
#(
    parameter int DB_CYC = DB_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic db
);

    localparam int DW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [DW-1:0] DLIM = DW'(DB_CYC - 1);

    logic          sync1;
    logic          btn_s;
    logic [DW-1:0] dcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn;
            btn_s <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db   <= 1'b0;
            dcnt <= '0;
        end else if (btn_s == db) begin
            dcnt <= '0;
        end else if (dcnt == DLIM) begin
            db   <= btn_s;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + DW'(1);
        end
    end

endmodule

// File: rtl/traffic_input_conditioner.sv
// Classifies debounced button presses as short or long and keeps the
// standby / test mode levels for the traffic light controller.
module traffic_input_conditioner
    import traffic_pkg::*;
#(
    parameter int DB_CYC   = DB_CYC_DEF,
    parameter int LONG_CYC = LONG_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic standby,
    output logic test,
    output logic short_pulse,
    output logic long_pulse
);

    localparam int HW = (LONG_CYC > 2) ? $clog2(LONG_CYC) : 1;
    // IDLE already spends the first db-high cycle, so PRESSED stops
    // one count early to land the strobe LONG_CYC cycles after the rise.
    localparam logic [HW-1:0] HLIM = HW'(LONG_CYC - 2);

    logic          db;
    press_state_t  state;
    press_state_t  state_nxt;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_nxt;
    logic          short_nxt;
    logic          long_nxt;

    btn_debouncer #(
        .DB_CYC(DB_CYC)
    ) u_db (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .db (db)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hcnt        <= '0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            state       <= state_nxt;
            hcnt        <= hcnt_nxt;
            short_pulse <= short_nxt;
            long_pulse  <= long_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (db) begin
                    state_nxt = PRESSED;
                    hcnt_nxt  = '0;
                end
            end
            PRESSED: begin
                if (!db) begin
                    short_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (hcnt == HLIM) begin
                    long_nxt  = 1'b1;
                    state_nxt = LONG_HELD;
                end else begin
                    hcnt_nxt = hcnt + HW'(1);
                end
            end
            LONG_HELD: begin
                if (!db) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Short presses are swallowed while in standby.
    always_ff @(posedge clk) begin
        if (rst) begin
            standby <= 1'b1;
            test    <= 1'b0;
        end else if (long_pulse) begin
            standby <= ~standby;
            test    <= 1'b0;
        end else if (short_pulse && !standby) begin
            test <= ~test;
        end
    end

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Randomised and directed bench for traffic_input_conditioner against
// a window-based behavioural model of debounce and press timing.
module tb_traffic_input_conditioner;

    localparam int DB   = 4;
    localparam int LC   = 16;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic standby;
    logic test;
    logic short_pulse;
    logic long_pulse;

    traffic_input_conditioner #(
        .DB_CYC  (DB),
        .LONG_CYC(LC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .standby    (standby),
        .test       (test),
        .short_pulse(short_pulse),
        .long_pulse (long_pulse)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state: raw samples per edge, debounced level, press bookkeeping.
    bit hist [MAXC];
    int n = 0;
    bit m_db = 0;
    bit m_sb = 1;
    bit m_ts = 0;
    bit m_sp = 0;
    bit m_lp = 0;
    bit long_done = 0;
    bit fall_short = 0;
    int last_flip = 0;
    int e_rise = 0;
    int fall_edge = -10;

    task automatic check(input string tag, input logic got,
                         input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s cycle %0d: got %b expected %b",
                         tag, n, got, exp);
        end
    endtask

    // True when the synced input disagreed with db on each of the
    // last DB edges ending at edge e.
    function automatic bit win_ok(input int e);
        for (int j = e - DB + 1; j <= e; j++) begin
            bit v;
            v = (j - 2 >= 0) ? hist[j - 2] : 1'b0;
            if (v == m_db) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model(input bit b, input bit r);
        bit nl;
        bit ns;
        if (r) begin
            hist[n] = 1'b0;
            if (n > 0) hist[n - 1] = 1'b0;
            m_db = 0;
            last_flip = n;
            m_sp = 0;
            m_lp = 0;
            m_sb = 1;
            m_ts = 0;
            long_done = 0;
            fall_edge = -10;
        end else begin
            hist[n] = b;
            if (m_lp) begin
                m_sb = !m_sb;
                m_ts = 0;
            end else if (m_sp && !m_sb) begin
                m_ts = !m_ts;
            end
            nl = m_db && !long_done && (n - e_rise == LC);
            if (nl) long_done = 1;
            ns = !m_db && (fall_edge == n - 1) && fall_short;
            m_lp = nl;
            m_sp = ns;
            if ((n - last_flip >= DB) && win_ok(n)) begin
                m_db = !m_db;
                last_flip = n;
                if (m_db) begin
                    e_rise = n;
                    long_done = 0;
                end else begin
                    fall_edge = n;
                    fall_short = !long_done;
                end
            end
        end
        n++;
    endtask

    task automatic step(input bit b, input bit r);
        if (n >= MAXC - 1) begin
            $display("FAIL cycle_budget: got %0d expected below %0d",
                     n, MAXC - 1);
            $fatal(1, "cycle budget exhausted");
        end
        btn = b;
        rst = r;
        @(posedge clk);
        #1;
        model(b, r);
        check("short_pulse", short_pulse, m_sp);
        check("long_pulse", long_pulse, m_lp);
        check("standby", standby, m_sb);
        check("test", test, m_ts);
        check("pulse_excl", short_pulse && long_pulse, 1'b0);
    endtask

    task automatic press(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
        for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("reset_standby", standby, 1'b1);
        check("reset_test", test, 1'b0);

        for (int i = 0; i < 20; i++) step(((i / 2) % 2) == 0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        check("bounce_standby", standby, 1'b1);

        press(30, 12);
        check("long_standby", standby, 1'b0);

        press(10, 12);
        check("short_test_on", test, 1'b1);
        press(10, 12);
        check("short_test_off", test, 1'b0);

        press(30, 12);
        check("long_back", standby, 1'b1);
        press(10, 12);
        check("stby_short_test", test, 1'b0);

        press(30, 12);
        press(15, 12);
        check("b15_short", test, 1'b1);
        press(16, 12);
        check("b16_standby", standby, 1'b1);
        check("b16_test", test, 1'b0);

        press(30, 12);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("midrst_standby", standby, 1'b1);
        press(10, 12);
        check("midrst_test", test, 1'b0);

        for (int k = 0; k < 40; k++) begin
            int len;
            int gap;
            len = $urandom_range(1, 24);
            gap = $urandom_range(2, 14);
            for (int i = 0; i < len; i++) begin
                bit b;
                bit r;
                b = ($urandom_range(0, 9) != 0);
                r = ($urandom_range(0, 60) == 0);
                step(b, r);
            end
            for (int i = 0; i < gap; i++) step(1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
